// File: rtl/serial_unsigned_compare_unit.sv
// -----------------------------------------------------------------------------
// serial_unsigned_compare_unit
//
// Bit-serial magnitude comparator for two WIDTH-bit unsigned operands. Both
// operands are captured in parallel on a load pulse and then shifted out one
// bit per clock; a 3-state FSM (EQ / LT / GT) accumulates the verdict.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high (priority over load)
//   load   in   start pulse; captures a_in, b_in and op
//   op     in   bit order: 0 = LSB-first, 1 = MSB-first
//   a_in   in   operand A (WIDTH bits, unsigned)
//   b_in   in   operand B (WIDTH bits, unsigned)
//   a_bit  out  current serial bit of A
//   b_bit  out  current serial bit of B
//   L/E/G  out  A<B / A==B / A>B, decoded from FSM state (exactly one high)
//   busy   out  compare in progress
//   done   out  result final; sticky until next load or rst
//
// Handshake: load is accepted on any edge with rst=0 (it aborts a running
// compare). L/E/G are only meaningful while done=1; busy and done are never
// high together.
//
// Optional feature macro: SERIAL_CMP_EARLY_EXIT_EN
//   When defined, an MSB-first compare finishes on the edge where the FSM
//   first leaves EQ. LSB-first and equal operands always take WIDTH clocks.
// -----------------------------------------------------------------------------
module serial_unsigned_compare_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             a_bit,
  output logic             b_bit,
  output logic             L,
  output logic             E,
  output logic             G,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  // count holds the number of bits already consumed; the edge that consumes
  // the final bit is the one where count still equals WIDTH-1.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_EQ = 2'd0,
    ST_LT = 2'd1,
    ST_GT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sra;
  logic [WIDTH-1:0] srb;
  logic             op_q;
  logic [CW-1:0]    count;
  logic             step;
  logic             finish;

  // Serial taps come straight from the shift registers.
  always_comb begin
    a_bit = sra[0];
    b_bit = srb[0];
    if (op_q) begin
      a_bit = sra[WIDTH-1];
      b_bit = srb[WIDTH-1];
    end
  end

  assign step = busy & ~load;

  // Next-state logic. LSB-first: every differing bit overrides the verdict
  // because later bits are more significant. MSB-first: the first differing
  // bit decides and LT/GT are absorbing.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = ST_EQ;
    end else if (step) begin
      if (!op_q || state == ST_EQ) begin
        if (a_bit && !b_bit) begin
          state_next = ST_GT;
        end else if (!a_bit && b_bit) begin
          state_next = ST_LT;
        end
      end
    end
  end

  always_comb begin
    finish = 1'b0;
    if (step) begin
      finish = (count == LAST);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      if (op_q && state == ST_EQ && (a_bit != b_bit)) begin
        finish = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EQ;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sra   <= '0;
      srb   <= '0;
      op_q  <= 1'b0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      sra   <= a_in;
      srb   <= b_in;
      op_q  <= op;
      count <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (step) begin
      if (op_q) begin
        sra <= {sra[WIDTH-2:0], 1'b0};
        srb <= {srb[WIDTH-2:0], 1'b0};
      end else begin
        sra <= {1'b0, sra[WIDTH-1:1]};
        srb <= {1'b0, srb[WIDTH-1:1]};
      end
      count <= count + 1'b1;
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign L = (state == ST_LT);
  assign E = (state == ST_EQ);
  assign G = (state == ST_GT);

endmodule

// File: tb/tb_serial_unsigned_compare_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_unsigned_compare_unit
//
// Directed plus random compares of serial_unsigned_compare_unit (WIDTH=32).
// Expected values come from a prefix-comparison model: after k serial bits
// the verdict equals an unsigned compare of the k bits seen so far (the low
// k bits in LSB-first order, the top k bits in MSB-first order).
// -----------------------------------------------------------------------------
module tb_serial_unsigned_compare_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         load;
  logic         op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         a_bit;
  logic         b_bit;
  logic         L;
  logic         E;
  logic         G;
  logic         busy;
  logic         done;

  int n_vec  = 0;
  int n_fail = 0;
  int cur_k  = 0;

  serial_unsigned_compare_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .op   (op),
    .a_in (a_in),
    .b_in (b_in),
    .a_bit(a_bit),
    .b_bit(b_bit),
    .L    (L),
    .E    (E),
    .G    (G),
    .busy (busy),
    .done (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // {L,E,G} after k serial bits have been consumed.
  function automatic logic [2:0] ref_leg(logic [W-1:0] a, logic [W-1:0] b,
                                         logic o, int k);
    logic [63:0] xa;
    logic [63:0] xb;
    if (!o) begin
      xa = {32'd0, a} & ((64'd1 << k) - 64'd1);
      xb = {32'd0, b} & ((64'd1 << k) - 64'd1);
    end else begin
      xa = {32'd0, a} >> (W - k);
      xb = {32'd0, b} >> (W - k);
    end
    if (xa < xb) return 3'b100;
    if (xa > xb) return 3'b001;
    return 3'b010;
  endfunction

  function automatic logic ref_bit(logic [W-1:0] v, logic o, int k);
    if (k >= W) return 1'b0;
    if (!o) return v[k];
    return v[W-1-k];
  endfunction

  // Number of clocks from the load edge until done rises.
  function automatic int ref_latency(logic [W-1:0] a, logic [W-1:0] b, logic o);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    logic [W-1:0] x;
    x = a ^ b;
    if (o && x != '0) begin
      for (int p = W - 1; p >= 0; p--) begin
        if (x[p]) return W - p;
      end
    end
`endif
    return W;
  endfunction

  // ---------------------------------------------------------------- checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_leg",  32'({L, E, G}), 32'(3'b010));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_taps", 32'({a_bit, b_bit}), 32'd0);
  endtask

  task automatic check_step(logic [W-1:0] a, logic [W-1:0] b, logic o, int k, int lat);
    int ke;
    ke    = (k < lat) ? k : lat;
    cur_k = k;
    chk("leg",   32'({L, E, G}), 32'(ref_leg(a, b, o, ke)));
    chk("a_bit", 32'(a_bit), 32'(ref_bit(a, o, ke)));
    chk("b_bit", 32'(b_bit), 32'(ref_bit(b, o, ke)));
    chk("busy",  32'(busy), 32'(k < lat));
    chk("done",  32'(done), 32'(k >= lat));
  endtask

  // ---------------------------------------------------------------- driver
  // Loads a compare and checks it every clock. abort_at>0 stops after that
  // many compare edges, leaving the compare running for the caller.
  // Inputs are scrambled while busy: they must be ignored.
  task automatic run_compare(logic [W-1:0] a, logic [W-1:0] b, logic o, int abort_at);
    int lat;
    int limit;
    lat   = ref_latency(a, b, o);
    limit = (abort_at > 0) ? abort_at : lat + 2;
    @(negedge clk);
    a_in = a;
    b_in = b;
    op   = o;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_step(a, b, o, 0, lat);
    for (int k = 1; k <= limit; k++) begin
      a_in = $urandom;
      b_in = $urandom;
      op   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_step(a, b, o, k, lat);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         ro;

    rst  = 1'b1;
    load = 1'b0;
    op   = 1'b0;
    a_in = '0;
    b_in = '0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values();

    // Directed compares.
    run_compare(32'd124, 32'd123, 1'b0, 0);
    run_compare(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 0);
    run_compare(32'h0, 32'hFFFFFFFF, 1'b0, 0);
    run_compare(32'h0, 32'hFFFFFFFF, 1'b1, 0);
    run_compare(32'h80000000, 32'h7FFFFFFF, 1'b0, 0);
    run_compare(32'h0, 32'h0, 1'b0, 0);
    run_compare(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0);
    run_compare(32'h40000000, 32'h0, 1'b1, 0);
    run_compare(32'h00000001, 32'h00000000, 1'b1, 0);

    // Reset in the middle of a compare.
    run_compare(32'h12345678, 32'h12345679, 1'b0, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_k = -1;
    check_reset_values();
    @(negedge clk);
    check_reset_values();

    // Reset wins over a simultaneous load.
    a_in = 32'hA5A5A5A5;
    b_in = 32'h1;
    op   = 1'b1;
    load = 1'b1;
    rst  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    rst  = 1'b0;
    cur_k = -2;
    check_reset_values();

    // Load in the middle of a compare restarts with new operands.
    run_compare(32'hFFFF0000, 32'h0000FFFF, 1'b1, 10);
    run_compare(32'd5, 32'd9, 1'b0, 0);

    // Random compares, biased towards equal and single-bit differences.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 2))
        0:       rb = $urandom;
        1:       rb = ra;
        default: rb = ra ^ (32'd1 << $urandom_range(0, W - 1));
      endcase
      ro = 1'($urandom_range(0, 1));
      run_compare(ra, rb, ro, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
